// File: rtl/write_ptr_full_ctrl_pkg.sv
// Shared definitions for the async FIFO pointer logic: default geometry and
// the binary/Gray conversion helpers used by both the write and read sides.
package write_ptr_full_ctrl_pkg;

  localparam int DEFAULT_ADDRESS_SIZE      = 3;
  localparam int DEFAULT_ALMOST_FULL_LEVEL = 6;

  // Widest pointer the helpers handle (ADDRESS_SIZE up to 15, plus wrap bit).
  localparam int PTR_MAX_W = 16;

  // Binary to reflected Gray code; narrower pointers are zero-extended by the caller.
  function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  // Reflected Gray code back to binary; zero-extended upper bits decode to zero.
  function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] gray);
    logic [PTR_MAX_W-1:0] bin;
    bin[PTR_MAX_W-1] = gray[PTR_MAX_W-1];
    for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/write_ptr_full_ctrl_gray_sync_2ff.sv
// Two-flop synchronizer for a Gray-coded pointer crossing into this clock
// domain. Only one bit changes per source update, so a bitwise resync is safe.
module gray_sync_2ff #(
  parameter int WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage1_q;
  logic [WIDTH-1:0] stage2_q;

  // Shift the foreign pointer through two flops; both stages clear on reset.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      stage1_q <= '0;
      stage2_q <= '0;
    end else begin
      stage1_q <= d_i;
      stage2_q <= stage1_q;
    end
  end

  assign q_o = stage2_q;

endmodule

// File: rtl/write_ptr_full_ctrl.sv
// Write-side pointer and full/level/overflow control for an asynchronous FIFO.
// Optional almost-full output is built only when WRITE_ALMOST_FULL_EN is defined.
module write_ptr_full_ctrl
  import write_ptr_full_ctrl_pkg::*;
#(
  parameter int ADDRESS_SIZE      = DEFAULT_ADDRESS_SIZE,
  parameter int ALMOST_FULL_LEVEL = DEFAULT_ALMOST_FULL_LEVEL
) (
  input  logic                  write_clk,
  input  logic                  write_reset_n,
  input  logic                  write_en,
  input  logic [ADDRESS_SIZE:0] read_pointer,
  input  logic                  overflow_clear,
  output logic [ADDRESS_SIZE:0] write_pointer,
  output logic [ADDRESS_SIZE-1:0] write_address,
  output logic                  write_full,
  output logic [ADDRESS_SIZE:0] write_level,
  output logic                  write_overflow
`ifdef WRITE_ALMOST_FULL_EN
  ,
  output logic                  write_almost_full
`endif
);

  localparam int PW = ADDRESS_SIZE + 1;

  // Reject geometries the pointer arithmetic cannot represent.
  if (ADDRESS_SIZE < 2 || ADDRESS_SIZE > 15) begin : g_bad_address_size
    $error("write_ptr_full_ctrl: ADDRESS_SIZE must be within 2..15");
  end
  if (ALMOST_FULL_LEVEL < 0 || ALMOST_FULL_LEVEL > (1 << ADDRESS_SIZE)) begin : g_bad_almost_full_level
    $error("write_ptr_full_ctrl: ALMOST_FULL_LEVEL must be within 0..2**ADDRESS_SIZE");
  end

  logic [PW-1:0] rq2;
  logic [PW-1:0] rbin;
  logic          accept;

  logic [PW-1:0] wbin_q;
  logic [PW-1:0] wbin_d;
  logic [PW-1:0] wgray_q;
  logic [PW-1:0] wgray_d;
  logic          full_q;
  logic          full_d;
  logic [PW-1:0] level_q;
  logic [PW-1:0] level_d;
  logic          overflow_q;
  logic          overflow_d;

  gray_sync_2ff #(
    .WIDTH(PW)
  ) u_read_ptr_sync (
    .clk_i    (write_clk),
    .reset_n_i(write_reset_n),
    .d_i      (read_pointer),
    .q_o      (rq2)
  );

  // Next-pointer, full, level and overflow computed from the post-accept pointer.
  always_comb begin
    accept     = write_en & ~full_q;
    wbin_d     = wbin_q + PW'(accept);
    wgray_d    = PW'(bin2gray(PTR_MAX_W'(wbin_d)));
    rbin       = PW'(gray2bin(PTR_MAX_W'(rq2)));
    full_d     = (wgray_d == {~rq2[PW-1:PW-2], rq2[PW-3:0]});
    level_d    = wbin_d - rbin;
    overflow_d = (write_en & full_q) | (overflow_q & ~overflow_clear);
  end

  // Pointer and status registers; reset clears them immediately, even mid-burst.
  always_ff @(posedge write_clk or negedge write_reset_n) begin
    if (!write_reset_n) begin
      wbin_q     <= '0;
      wgray_q    <= '0;
      full_q     <= 1'b0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wbin_q     <= wbin_d;
      wgray_q    <= wgray_d;
      full_q     <= full_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
    end
  end

  assign write_pointer  = wgray_q;
  assign write_address  = wbin_q[ADDRESS_SIZE-1:0];
  assign write_full     = full_q;
  assign write_level    = level_q;
  assign write_overflow = overflow_q;

`ifdef WRITE_ALMOST_FULL_EN
  logic almost_full_q;
  logic almost_full_d;

  // Almost-full threshold uses the same pessimistic occupancy as write_level.
  always_comb begin
    almost_full_d = (32'(level_d) >= ALMOST_FULL_LEVEL);
  end

  // Register almost-full alongside the other status flags.
  always_ff @(posedge write_clk or negedge write_reset_n) begin
    if (!write_reset_n) begin
      almost_full_q <= 1'b0;
    end else begin
      almost_full_q <= almost_full_d;
    end
  end

  assign write_almost_full = almost_full_q;
`endif

endmodule

// File: tb/tb_write_ptr_full_ctrl.sv
// Directed self-checking bench for write_ptr_full_ctrl at default geometry
// (8-deep FIFO, 4-bit pointers). Almost-full checks follow WRITE_ALMOST_FULL_EN.
module tb_write_ptr_full_ctrl;

  logic       write_clk;
  logic       write_reset_n;
  logic       write_en;
  logic [3:0] read_pointer;
  logic       overflow_clear;
  logic [3:0] write_pointer;
  logic [2:0] write_address;
  logic       write_full;
  logic [3:0] write_level;
  logic       write_overflow;
`ifdef WRITE_ALMOST_FULL_EN
  logic       write_almost_full;
`endif

  int compareCount  = 0;
  int mismatchCount = 0;

  write_ptr_full_ctrl dut (
    .write_clk        (write_clk),
    .write_reset_n    (write_reset_n),
    .write_en         (write_en),
    .read_pointer     (read_pointer),
    .overflow_clear   (overflow_clear),
    .write_pointer    (write_pointer),
    .write_address    (write_address),
    .write_full       (write_full),
    .write_level      (write_level),
    .write_overflow   (write_overflow)
`ifdef WRITE_ALMOST_FULL_EN
    ,
    .write_almost_full(write_almost_full)
`endif
  );

  // Free-running write clock, rising edges at 5, 15, 25 ...
  initial begin
    write_clk = 1'b0;
    forever #5 write_clk = ~write_clk;
  end

  // Abort guard so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [3:0] toGray(input logic [3:0] v);
    return v ^ (v >> 1);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge write_clk);
    #1;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_ptr"},      32'(write_pointer),  32'd0);
    checkOutput({tag, "_addr"},     32'(write_address),  32'd0);
    checkOutput({tag, "_full"},     32'(write_full),     32'd0);
    checkOutput({tag, "_level"},    32'(write_level),    32'd0);
    checkOutput({tag, "_overflow"}, 32'(write_overflow), 32'd0);
`ifdef WRITE_ALMOST_FULL_EN
    checkOutput({tag, "_afull"},    32'(write_almost_full), 32'd0);
`endif
  endtask

  // Consecutive accepted writes from a known pointer and occupancy.
  task automatic applyStimulus(input logic [3:0] startWbin, input int startLevel, input int count);
    logic [3:0] wbinExp;
    int levelExp;
    wbinExp  = startWbin;
    levelExp = startLevel;
    write_en = 1'b1;
    for (int i = 0; i < count; i++) begin
      checkOutput("wrAddr", 32'(write_address), 32'(wbinExp[2:0]));
      step();
      wbinExp  = wbinExp + 4'd1;
      levelExp = levelExp + 1;
      checkOutput("wrLevel", 32'(write_level),   32'(levelExp));
      checkOutput("wrFull",  32'(write_full),    32'(levelExp == 8));
      checkOutput("wrPtr",   32'(write_pointer), 32'(toGray(wbinExp)));
`ifdef WRITE_ALMOST_FULL_EN
      checkOutput("wrAlmostFull", 32'(write_almost_full), 32'(levelExp >= 6));
`endif
    end
  endtask

  // Move the read pointer with writes idle; old occupancy holds for two edges.
  task automatic moveRead(input logic [3:0] grayPtr, input int prevLevel, input int newLevel);
    int expLevel;
    write_en     = 1'b0;
    read_pointer = grayPtr;
    for (int e = 1; e <= 3; e++) begin
      step();
      expLevel = (e < 3) ? prevLevel : newLevel;
      checkOutput("rdLevel", 32'(write_level), 32'(expLevel));
      checkOutput("rdFull",  32'(write_full),  32'(expLevel == 8));
`ifdef WRITE_ALMOST_FULL_EN
      checkOutput("rdAlmostFull", 32'(write_almost_full), 32'(expLevel >= 6));
`endif
    end
  endtask

  initial begin
    write_reset_n  = 1'b0;
    write_en       = 1'b0;
    read_pointer   = 4'd0;
    overflow_clear = 1'b0;
    #12;
    checkResetOutputs("por");
    write_reset_n = 1'b1;

    // Fill an empty FIFO: addresses 0..7, full on the eighth edge.
    applyStimulus(4'd0, 0, 8);
    checkOutput("fillOverflow", 32'(write_overflow), 32'd0);

    // Write attempt while full sets the sticky flag and leaves the pointer alone.
    write_en = 1'b1;
    step();
    checkOutput("ovfSet",   32'(write_overflow), 32'd1);
    checkOutput("ovfAddr",  32'(write_address),  32'd0);
    checkOutput("ovfPtr",   32'(write_pointer),  32'(toGray(4'd8)));
    checkOutput("ovfLevel", 32'(write_level),    32'd8);
    overflow_clear = 1'b1;
    step();
    checkOutput("ovfSetWins", 32'(write_overflow), 32'd1);
    checkOutput("ovfPtrHeld", 32'(write_pointer),  32'(toGray(4'd8)));
    write_en = 1'b0;
    step();
    checkOutput("ovfCleared", 32'(write_overflow), 32'd0);
    overflow_clear = 1'b0;

    // Reader consumes two entries; full drops on the third edge.
    moveRead(toGray(4'd2), 8, 6);

    // Wrap: 20 writes interleaved with reader advances.
    applyStimulus(4'd8, 6, 2);
    moveRead(toGray(4'd6), 8, 4);
    applyStimulus(4'd10, 4, 4);
    moveRead(toGray(4'd12), 8, 2);
    applyStimulus(4'd14, 2, 6);
    moveRead(toGray(4'd4), 8, 0);
    applyStimulus(4'd4, 0, 8);

    // Overflow after the wrap, then asynchronous reset clears everything.
    write_en = 1'b1;
    step();
    checkOutput("wrapOvf",  32'(write_overflow), 32'd1);
    checkOutput("wrapAddr", 32'(write_address),  32'd4);
    write_en = 1'b0;
    #2;
    write_reset_n = 1'b0;
    read_pointer  = 4'd0;
    #1;
    checkResetOutputs("rstFull");
    step();
    write_reset_n = 1'b1;

    // Reset mid-burst at wbin=5, then the next write lands on address 0.
    applyStimulus(4'd0, 0, 5);
    #2;
    write_reset_n = 1'b0;
    #1;
    checkResetOutputs("rstBurst");
    step();
    write_reset_n = 1'b1;
    applyStimulus(4'd0, 0, 6);

    // One read brings the level from 6 to 5 and drops almost-full.
    moveRead(toGray(4'd1), 6, 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
